// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register file write port between NUM_REQ writeback requesters and tracks pending writes.
// Define REGFILE_ARB_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed priority with the lowest index winning.
module regfile_write_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 4,
  parameter int NUM_REGS   = 2**SEL_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*SEL_WIDTH-1:0]  req_sel,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          reserve_en,
  input  logic [SEL_WIDTH-1:0]          reserve_sel,
  output logic                          rf_write_en,
  output logic [SEL_WIDTH-1:0]          rf_write_sel,
  output logic [DATA_WIDTH-1:0]         rf_write_data,
  output logic [NUM_REGS-1:0]           busy
);
  localparam int IDX_W = $clog2(NUM_REQ);
  logic [IDX_W-1:0]      gnt_idx, cand;
  logic                  gnt_found, xfer;
  logic [SEL_WIDTH-1:0]  gnt_sel;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic                  we_q, we_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d, clr_vec, set_vec;
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0]      ptr_q, ptr_d;
`endif
  // Scanning from the far end and overwriting leaves the first candidate in search order.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
      cand = IDX_W'((int'(ptr_q) + 1 + k) % NUM_REQ);
`else
      cand = IDX_W'(k);
`endif
      if (req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end
  assign req_ready = (gnt_found && rst_n) ? NUM_REQ'(1) << gnt_idx : '0;
  assign xfer      = gnt_found && rst_n;
  assign gnt_sel   = req_sel[int'(gnt_idx)*SEL_WIDTH +: SEL_WIDTH];
  assign gnt_data  = req_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
  // Writes to register 0 complete the handshake but never reach the register file.
  assign we_d   = xfer && (gnt_sel != '0);
  assign sel_d  = xfer ? gnt_sel : sel_q;
  assign data_d = xfer ? gnt_data : data_q;
  assign clr_vec = NUM_REGS'(we_q) << sel_q;
  assign set_vec = (reserve_en && reserve_sel != '0) ? NUM_REGS'(1) << reserve_sel : '0;
  assign busy_d  = ((busy_q & ~clr_vec) | set_vec) & ~NUM_REGS'(1);
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
  assign ptr_d = xfer ? gnt_idx : ptr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= IDX_W'(NUM_REQ - 1);
    else        ptr_q <= ptr_d;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      sel_q  <= '0;
      data_q <= '0;
      busy_q <= '0;
    end else begin
      we_q   <= we_d;
      sel_q  <= sel_d;
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end
  assign rf_write_en   = we_q;
  assign rf_write_sel  = sel_q;
  assign rf_write_data = data_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed checks of arbitration, write latency, register 0 handling, scoreboard and reset.
module tb_regfile_write_arbiter;
  localparam int NR = 3, DW = 32, SW = 4, NG = 16;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [NR-1:0] req_valid = '0, req_ready;
  logic [NR*SW-1:0] req_sel = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic reserve_en = 1'b0;
  logic [SW-1:0] reserve_sel = '0;
  logic rf_write_en;
  logic [SW-1:0] rf_write_sel;
  logic [DW-1:0] rf_write_data;
  logic [NG-1:0] busy;
  int total = 0, bad = 0;

  regfile_write_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .NUM_REGS(NG)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_sel(req_sel), .req_data(req_data),
    .req_ready(req_ready), .reserve_en(reserve_en), .reserve_sel(reserve_sel),
    .rf_write_en(rf_write_en), .rf_write_sel(rf_write_sel), .rf_write_data(rf_write_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    reserve_en = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    req_valid = '1;
    #1;
    total++; if (rf_write_en !== 1'b0) begin bad++; $display("FAIL reset_en got=%b exp=0", rf_write_en); end
    total++; if (rf_write_sel !== 4'd0) begin bad++; $display("FAIL reset_sel got=%h exp=0", rf_write_sel); end
    total++; if (rf_write_data !== 32'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", rf_write_data); end
    total++; if (busy !== 16'h0000) begin bad++; $display("FAIL reset_busy got=%h exp=0000", busy); end
    total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
    req_valid = '0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    total++; if (rf_write_en !== 1'b0) begin bad++; $display("FAIL post_reset_en got=%b exp=0", rf_write_en); end
  endtask

  task automatic test_priority();
    logic [DW-1:0] d [NR];
    logic [NR-1:0] exp_rdy;
    logic [SW-1:0] last_sel;
    d = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
    for (int i = 0; i < NR; i++) begin
      req_sel[i*SW +: SW] = SW'(i + 1);
      req_data[i*DW +: DW] = d[i];
    end
    req_valid = 3'b111;
    #1;
    for (int i = 0; i < NR; i++) begin
      exp_rdy = 3'b001 << i;
      total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL prio_ready%0d got=%b exp=%b", i, req_ready, exp_rdy); end
      step();
      total++; if (rf_write_en !== 1'b1 || rf_write_sel !== SW'(i + 1) || rf_write_data !== d[i])
        begin bad++; $display("FAIL prio_write%0d got en=%b sel=%h data=%h exp en=1 sel=%h data=%h", i, rf_write_en, rf_write_sel, rf_write_data, i + 1, d[i]); end
      req_valid[i] = 1'b0;
      #1;
    end
    last_sel = 4'd3;
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
    req_valid = 3'b111;
    #1;
    total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL rr_wrap_ready got=%b exp=001", req_ready); end
    step();
    req_valid = '0;
    last_sel = 4'd1;
`endif
    step();
    total++; if (rf_write_en !== 1'b0 || rf_write_sel !== last_sel)
      begin bad++; $display("FAIL idle_hold got en=%b sel=%h exp en=0 sel=%h", rf_write_en, rf_write_sel, last_sel); end
    total++; if (busy !== 16'h0000) begin bad++; $display("FAIL nonbusy_write got=%h exp=0000", busy); end
  endtask

`ifdef REGFILE_ARB_ROUND_ROBIN_EN
  task automatic test_round_robin();
    logic [NR-1:0] exp_rdy;
    logic [SW-1:0] exp_sel;
    do_reset();
    req_sel[0 +: SW] = 4'd1;
    req_sel[2*SW +: SW] = 4'd3;
    req_valid = 3'b101;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_rdy = (i % 2 == 0) ? 3'b001 : 3'b100;
      exp_sel = (i % 2 == 0) ? 4'd1 : 4'd3;
      total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL rr_alt_ready%0d got=%b exp=%b", i, req_ready, exp_rdy); end
      step();
      total++; if (rf_write_en !== 1'b1 || rf_write_sel !== exp_sel)
        begin bad++; $display("FAIL rr_alt_write%0d got en=%b sel=%h exp en=1 sel=%h", i, rf_write_en, rf_write_sel, exp_sel); end
    end
    req_valid = '0;
    step();
  endtask
`endif

  task automatic test_scoreboard();
    reserve_en = 1'b1;
    reserve_sel = 4'd5;
    step();
    reserve_en = 1'b0;
    total++; if (busy !== 16'h0020) begin bad++; $display("FAIL sb_set got=%h exp=0020", busy); end
    step();
    total++; if (busy !== 16'h0020) begin bad++; $display("FAIL sb_hold got=%h exp=0020", busy); end
    req_sel[SW +: SW] = 4'd5;
    req_data[DW +: DW] = 32'hDEADBEEF;
    req_valid = 3'b010;
    #1;
    total++; if (req_ready !== 3'b010) begin bad++; $display("FAIL sb_ready got=%b exp=010", req_ready); end
    step();
    req_valid = '0;
    total++; if (rf_write_en !== 1'b1 || rf_write_sel !== 4'd5 || rf_write_data !== 32'hDEADBEEF)
      begin bad++; $display("FAIL sb_write got en=%b sel=%h data=%h exp en=1 sel=5 data=deadbeef", rf_write_en, rf_write_sel, rf_write_data); end
    total++; if (busy !== 16'h0020) begin bad++; $display("FAIL sb_busy_during_write got=%h exp=0020", busy); end
    step();
    total++; if (busy !== 16'h0000 || rf_write_en !== 1'b0)
      begin bad++; $display("FAIL sb_clear got busy=%h en=%b exp busy=0000 en=0", busy, rf_write_en); end
  endtask

  task automatic test_set_wins();
    reserve_en = 1'b1;
    reserve_sel = 4'd7;
    step();
    reserve_en = 1'b0;
    total++; if (busy !== 16'h0080) begin bad++; $display("FAIL sw_reserve got=%h exp=0080", busy); end
    req_sel[2*SW +: SW] = 4'd7;
    req_data[2*DW +: DW] = 32'h0000_0077;
    req_valid = 3'b100;
    #1;
    total++; if (req_ready !== 3'b100) begin bad++; $display("FAIL sw_ready got=%b exp=100", req_ready); end
    step();
    req_valid = '0;
    total++; if (rf_write_en !== 1'b1 || rf_write_sel !== 4'd7)
      begin bad++; $display("FAIL sw_write got en=%b sel=%h exp en=1 sel=7", rf_write_en, rf_write_sel); end
    reserve_en = 1'b1;
    reserve_sel = 4'd7;
    step();
    reserve_en = 1'b0;
    total++; if (busy !== 16'h0080) begin bad++; $display("FAIL sw_set_wins got=%h exp=0080", busy); end
    req_valid = 3'b100;
    step();
    req_valid = '0;
    step();
    total++; if (busy !== 16'h0000) begin bad++; $display("FAIL sw_single_clear got=%h exp=0000", busy); end
  endtask

  task automatic test_reg_zero();
    reserve_en = 1'b1;
    reserve_sel = 4'd4;
    step();
    req_sel[0 +: SW] = 4'd0;
    req_data[0 +: DW] = 32'h0000_1234;
    req_valid = 3'b001;
    reserve_sel = 4'd0;
    #1;
    total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL r0_ready got=%b exp=001", req_ready); end
    step();
    req_valid = '0;
    reserve_en = 1'b0;
    #1;
    total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL r0_ready_drop got=%b exp=000", req_ready); end
    total++; if (rf_write_en !== 1'b0) begin bad++; $display("FAIL r0_no_write got=%b exp=0", rf_write_en); end
    total++; if (busy !== 16'h0010) begin bad++; $display("FAIL r0_busy got=%h exp=0010", busy); end
    step();
    total++; if (rf_write_en !== 1'b0 || busy !== 16'h0010)
      begin bad++; $display("FAIL r0_after got en=%b busy=%h exp en=0 busy=0010", rf_write_en, busy); end
  endtask

  task automatic test_reset_midop();
    reserve_en = 1'b1;
    for (int r = 5; r <= 7; r++) begin
      reserve_sel = SW'(r);
      step();
    end
    reserve_en = 1'b0;
    total++; if (busy !== 16'h00F0) begin bad++; $display("FAIL mid_busy_setup got=%h exp=00f0", busy); end
    req_sel = {4'd3, 4'd9, 4'd1};
    req_valid = 3'b010;
    step();
    req_valid = 3'b111;
    #1;
    total++; if (rf_write_en !== 1'b1 || rf_write_sel !== 4'd9)
      begin bad++; $display("FAIL mid_pending got en=%b sel=%h exp en=1 sel=9", rf_write_en, rf_write_sel); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (rf_write_en !== 1'b0) begin bad++; $display("FAIL mid_en_flush got=%b exp=0", rf_write_en); end
    total++; if (busy !== 16'h0000) begin bad++; $display("FAIL mid_busy_flush got=%h exp=0000", busy); end
    total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL mid_ready_in_reset got=%b exp=000", req_ready); end
    step();
    step();
    rst_n = 1'b1;
    #1;
    total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL mid_rearb got=%b exp=001", req_ready); end
    step();
    req_valid = '0;
    total++; if (rf_write_en !== 1'b1 || rf_write_sel !== 4'd1)
      begin bad++; $display("FAIL mid_first_write got en=%b sel=%h exp en=1 sel=1", rf_write_en, rf_write_sel); end
  endtask

  initial begin
    test_reset();
    test_priority();
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
    test_round_robin();
`endif
    test_scoreboard();
    test_set_wins();
    test_reg_zero();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
